// File: rtl/run_detect_pkg.sv
// ----------------------------------------------------------------------------
// run_detect_pkg
//   Shared types, default sizing and helpers for the multi-channel
//   run-of-ones detector and the round-robin lane arbiter.
//
//   Contents:
//     NUM_CH_DEFAULT / THRESH_DEFAULT   default channel count and run threshold
//     CH_W_DEFAULT / CNT_W_DEFAULT      derived index / counter widths
//     ch_idx_t                          channel index at default sizing
//     cnt_t                             run counter at default sizing
//     sat_inc(cnt, thresh)              saturating increment, caps at thresh
// ----------------------------------------------------------------------------
package run_detect_pkg;

  localparam int NUM_CH_DEFAULT = 4;
  localparam int THRESH_DEFAULT = 2;
  localparam int CH_W_DEFAULT   = $clog2(NUM_CH_DEFAULT);
  localparam int CNT_W_DEFAULT  = $clog2(THRESH_DEFAULT + 1);

  typedef logic [CH_W_DEFAULT-1:0]  ch_idx_t;
  typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

  // Saturating increment: once the run reaches thresh it stays there, so a
  // long run of ones can never wrap the counter back through THRESH-1 and
  // retrigger an event.
  function automatic int unsigned sat_inc(input int unsigned cnt,
                                          input int unsigned thresh);
    return (cnt >= thresh) ? thresh : cnt + 1;
  endfunction

endpackage

// File: rtl/run_detect_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter. Grants the first requesting channel
//   found when searching ptr, ptr+1, ..., NUM_CH-1, 0, ..., ptr-1. The caller
//   owns the pointer register, so the same arbiter can serve any lane
//   scheduler that wants a different pointer-update policy.
//
//   Ports:
//     req      in  NUM_CH  request vector
//     ptr      in  CH_W    highest-priority channel this cycle
//     en       in  1       0 forces an empty grant
//     gnt      out NUM_CH  one-hot grant (all-zero when nothing granted)
//     gnt_idx  out CH_W    index of the granted channel (0 when none)
// ----------------------------------------------------------------------------
module rr_arbiter
  import run_detect_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEFAULT,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx
);

  int              idx;
  logic [CH_W-1:0] idx_c;
  logic            found;

  // Walk the channels in priority order starting at ptr; the first request
  // seen wins and the found flag suppresses every later candidate, which
  // keeps the grant one-hot by construction.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    idx_c   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) begin
        idx = idx - NUM_CH;
      end
      idx_c = CH_W'(idx);
      if (en && !found && req[idx_c]) begin
        found        = 1'b1;
        gnt[idx_c]   = 1'b1;
        gnt_idx      = idx_c;
      end
    end
  end

endmodule

// File: rtl/run_detect_scheduler.sv
// ----------------------------------------------------------------------------
// run_detect_scheduler
//   Shares one saturating run-of-ones detector across NUM_CH bit-serial
//   lanes. Each cycle the round-robin arbiter accepts at most one lane's bit,
//   which updates that lane's saved run count. When a lane's run first
//   reaches THRESH, its index is posted on a valid/ready event port.
//
//   Ports:
//     clock     in  1       rising-edge clock
//     reset     in  1       asynchronous active-low reset (0 = in reset)
//     enable    in  1       1 = arbitration runs, 0 = no grants, state held
//     in_valid  in  NUM_CH  lane i has a bit available
//     in_bit    in  NUM_CH  serial data bit per lane
//     in_ready  out NUM_CH  one-hot grant; bit accepted on valid & ready
//     clr       in  NUM_CH  synchronous clear of a lane's run count
//     ev_valid  out 1       event pending
//     ev_ch     out CH_W    lane index of the pending event
//     ev_ready  in  1       consumer accepts the event
//     match     out NUM_CH  registered level, run count == THRESH
// ----------------------------------------------------------------------------
module run_detect_scheduler
  import run_detect_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEFAULT,
  parameter int THRESH = THRESH_DEFAULT,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int CNT_W  = $clog2(THRESH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] in_valid,
  input  logic [NUM_CH-1:0] in_bit,
  output logic [NUM_CH-1:0] in_ready,
  input  logic [NUM_CH-1:0] clr,
  output logic              ev_valid,
  output logic [CH_W-1:0]   ev_ch,
  input  logic              ev_ready,
  output logic [NUM_CH-1:0] match
);

  localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESH - 1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

  logic [CH_W-1:0]   ptr_reg;
  logic [CH_W-1:0]   ptr_next;
  logic              ev_valid_reg;
  logic [CH_W-1:0]   ev_ch_reg;

  logic              stall;
  logic              arb_en;
  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic [NUM_CH-1:0] acc_vec;
  logic [NUM_CH-1:0] hit_vec;
  logic              accept;
  logic              ev_load;

  // While an event sits unaccepted no lane is granted, so no second event
  // can be produced that would need to overwrite the pending one.
  assign stall  = ev_valid_reg & ~ev_ready;

  // Including reset here keeps in_ready low for the whole reset window even
  // though the request vector itself is not reset.
  assign arb_en = enable & ~stall & reset;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr_reg),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign in_ready = gnt;
  assign acc_vec  = in_valid & gnt;
  assign accept   = |acc_vec;

  // At most one lane is accepted per cycle, so at most one hit bit is set
  // and the granted index identifies it.
  assign ev_load  = |hit_vec;

  assign ptr_next = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;

  // --------------------------------------------------------------------------
  // Per-lane run counter and match flag
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             match_reg;

    // clr has priority over an accept on the same lane; the pointer still
    // advances because that is driven from the grant, not from the count.
    always_comb begin
      cnt_next = cnt_reg;
      if (clr[gi]) begin
        cnt_next = '0;
      end else if (acc_vec[gi]) begin
        if (in_bit[gi]) begin
          cnt_next = CNT_W'(sat_inc(32'(cnt_reg), THRESH));
        end else begin
          cnt_next = '0;
        end
      end
    end

    // Only the THRESH-1 -> THRESH transition fires, so a saturated lane
    // receiving more ones stays silent.
    assign hit_vec[gi] = acc_vec[gi] & ~clr[gi] & in_bit[gi] &
                         (cnt_reg == THRESH_M1);

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt_reg   <= '0;
        match_reg <= 1'b0;
      end else begin
        cnt_reg   <= cnt_next;
        // Taken from the next-state count so match rises together with
        // ev_valid rather than a cycle later.
        match_reg <= (cnt_next == THRESH_C);
      end
    end

    assign match[gi] = match_reg;
  end

  // --------------------------------------------------------------------------
  // Round-robin pointer and event register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_reg      <= '0;
      ev_valid_reg <= 1'b0;
      ev_ch_reg    <= '0;
    end else begin
      if (accept) begin
        ptr_reg <= ptr_next;
      end
      // A new event may load in the same cycle the old one is taken,
      // giving back-to-back events with no bubble.
      if (ev_load) begin
        ev_valid_reg <= 1'b1;
        ev_ch_reg    <= gnt_idx;
      end else if (ev_ready) begin
        ev_valid_reg <= 1'b0;
      end
    end
  end

  assign ev_valid = ev_valid_reg;
  assign ev_ch    = ev_ch_reg;

endmodule

// File: tb/tb_run_detect_scheduler.sv
module tb_run_detect_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] in_valid = '0;
  logic [3:0] in_bit = '0;
  logic [3:0] clr = '0;
  logic       ev_ready = 1'b0;
  logic [3:0] in_ready;
  logic       ev_valid;
  logic [1:0] ev_ch;
  logic [3:0] match;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int exp_ch;

  run_detect_scheduler #(
    .NUM_CH (4),
    .THRESH (2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_ready (in_ready),
    .clr      (clr),
    .ev_valid (ev_valid),
    .ev_ch    (ev_ch),
    .ev_ready (ev_ready),
    .match    (match)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s value=%0h t=%0t", name, act, $time);
    end
  endtask

  // Inputs change on the falling edge; comb outputs are checked 1 ns later.
  task automatic drive(input logic [3:0] v, input logic [3:0] b,
                       input logic [3:0] c, input logic en, input logic rdy);
    @(negedge clock);
    in_valid = v;
    in_bit   = b;
    clr      = c;
    enable   = en;
    ev_ready = rdy;
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset    = 1'b0;
    in_valid = '0;
    in_bit   = '0;
    clr      = '0;
    enable   = 1'b0;
    ev_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every completed event handshake.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (reset && ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ev_unexpected actual_ch=%0d required=none t=%0t",
                   ev_ch, $time);
        end else begin
          exp_ch = exp_q.pop_front();
          chk("ev_ch", 32'(ev_ch), 32'(exp_ch));
        end
      end
    end
  end

  initial begin
    // ---------------- reset state ----------------
    reset    = 1'b0;
    in_valid = 4'hF;
    enable   = 1'b1;
    #12;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_ev_valid", 32'(ev_valid), 0);
    chk("rst_ev_ch", 32'(ev_ch), 0);
    chk("rst_match", 32'(match), 0);
    reset_dut();

    // ---------------- T1: ch0 bits 1,1,1,0 ----------------
    drive(4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b1);
    chk("t1_rdy_a", 32'(in_ready), 32'h1);
    chk("t1_match_a", 32'(match[0]), 0);
    drive(4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b1);
    exp_q.push_back(0);
    chk("t1_match_b", 32'(match[0]), 0);
    chk("t1_evv_b", 32'(ev_valid), 0);
    drive(4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b1);
    chk("t1_match_c", 32'(match[0]), 1);
    chk("t1_evv_c", 32'(ev_valid), 1);
    drive(4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1);
    chk("t1_match_d", 32'(match[0]), 1);
    chk("t1_evv_d", 32'(ev_valid), 0);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    chk("t1_match_e", 32'(match[0]), 0);
    chk("t1_evv_e", 32'(ev_valid), 0);
    chk("t1_pending", 32'(exp_q.size()), 0);

    // ---------------- T2: round robin over all lanes ----------------
    reset_dut();
    for (int k = 0; k < 5; k++) begin
      drive(4'hF, 4'h0, 4'h0, 1'b1, 1'b1);
      chk("t2_grant", 32'(in_ready), 32'(1 << (k % 4)));
    end
    drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    chk("t2_evv", 32'(ev_valid), 0);

    // ---------------- T3: stall with two events ----------------
    reset_dut();
    drive(4'b1010, 4'b1010, 4'b0000, 1'b1, 1'b0);
    chk("t3_rdy1", 32'(in_ready), 32'b0010);
    drive(4'b1010, 4'b1010, 4'b0000, 1'b1, 1'b0);
    chk("t3_rdy2", 32'(in_ready), 32'b1000);
    drive(4'b1010, 4'b1010, 4'b0000, 1'b1, 1'b0);
    chk("t3_rdy3", 32'(in_ready), 32'b0010);
    exp_q.push_back(1);
    for (int k = 0; k < 2; k++) begin
      drive(4'b1010, 4'b1010, 4'b0000, 1'b1, 1'b0);
      chk("t3_stall_rdy", 32'(in_ready), 0);
      chk("t3_stall_evv", 32'(ev_valid), 1);
      chk("t3_stall_evch", 32'(ev_ch), 1);
    end
    drive(4'b1010, 4'b1010, 4'b0000, 1'b1, 1'b1);
    chk("t3_resume_rdy", 32'(in_ready), 32'b1000);
    exp_q.push_back(3);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    chk("t3_b2b_evv", 32'(ev_valid), 1);
    chk("t3_b2b_evch", 32'(ev_ch), 3);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    chk("t3_end_evv", 32'(ev_valid), 0);
    chk("t3_match", 32'(match), 32'b1010);
    chk("t3_pending", 32'(exp_q.size()), 0);

    // ---------------- T4: clr beats an accept ----------------
    reset_dut();
    drive(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b1);
    chk("t4_rdy1", 32'(in_ready), 32'b0100);
    drive(4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1);
    chk("t4_rdy2", 32'(in_ready), 32'b0100);
    drive(4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b1);
    chk("t4_ptr3", 32'(in_ready), 32'b1000);
    chk("t4_evv", 32'(ev_valid), 0);
    chk("t4_match", 32'(match), 0);
    drive(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b1);
    chk("t4_rdy4", 32'(in_ready), 32'b0100);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    chk("t4_cnt_cleared", 32'(match), 0);
    chk("t4_evv_end", 32'(ev_valid), 0);

    // ---------------- T5: enable low holds state ----------------
    reset_dut();
    drive(4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b1);
    chk("t5_rdy0", 32'(in_ready), 32'b0001);
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1);
      chk("t5_dis_rdy", 32'(in_ready), 0);
    end
    chk("t5_dis_match", 32'(match), 0);
    drive(4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b1);
    chk("t5_resume", 32'(in_ready), 32'b0010);
    drive(4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b1);
    chk("t5_rdy_ch0", 32'(in_ready), 32'b0001);
    exp_q.push_back(0);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    chk("t5_evv", 32'(ev_valid), 1);
    chk("t5_match", 32'(match), 32'b0001);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    chk("t5_evv_end", 32'(ev_valid), 0);
    chk("t5_pending", 32'(exp_q.size()), 0);

    // ---------------- T6: async reset with pending event ----------------
    reset_dut();
    drive(4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0);
    drive(4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
    chk("t6_pre_evv", 32'(ev_valid), 1);
    chk("t6_pre_match", 32'(match), 32'b0001);
    #1;
    in_valid = 4'hF;
    #1;
    reset = 1'b0;
    #1;
    chk("t6_async_evv", 32'(ev_valid), 0);
    chk("t6_async_match", 32'(match), 0);
    chk("t6_async_rdy", 32'(in_ready), 0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    drive(4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b1);
    chk("t6_rdy", 32'(in_ready), 32'b0001);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    chk("t6_cnt_zero", 32'(match), 0);
    chk("t6_evv", 32'(ev_valid), 0);
    chk("t6_pending", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_detect_scheduler.md
Name: run_detect_scheduler

Overview:
- Time-multiplexes one saturating run-of-ones detector across NUM_CH bit-serial input channels.
- Each cycle, a round-robin arbiter grants at most one channel. The granted channel's bit updates that channel's saved run count.
- When a channel's run first reaches THRESH, the block posts a per-channel event on a valid/ready output.
- Sits between the serial front-end lanes and the event/interrupt collector; it generalises the two-consecutive-ones detector to shared, multi-channel, configurable-threshold use.

Parameters:
- NUM_CH, 4, number of input channels (>=2).
- THRESH, 2, consecutive ones needed to match (>=1).
- CH_W, $clog2(NUM_CH), channel-index width.
- CNT_W, $clog2(THRESH+1), run-counter width.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- enable  in  1  1 = arbitration runs; 0 = no grants, all state held.
- in_valid  in  NUM_CH  channel i has a bit available.
- in_bit  in  NUM_CH  serial data bit per channel.
- in_ready  out  NUM_CH  one-hot grant; bit i accepted when in_valid[i] & in_ready[i].
- clr  in  NUM_CH  per-channel synchronous clear of run count.
- ev_valid  out  1  event pending.
- ev_ch  out  CH_W  channel index of the pending event.
- ev_ready  in  1  consumer accepts the event.
- match  out  NUM_CH  registered level: cnt[i] == THRESH.

Behaviour:
- Reset (async assert, sync release): cnt[*]=0, ptr=0, ev_valid=0, ev_ch=0, match=0. in_ready is all-zero during reset.
- Stall: stall = ev_valid & ~ev_ready.
- Grant (combinational): if enable & ~stall, grant the first i with in_valid[i], searching ptr, ptr+1, ..., NUM_CH-1, 0, ..., ptr-1 (wrap-around). in_ready = one-hot(grant). Otherwise in_ready = 0.
- in_ready never depends on in_bit. At most one bit of in_ready is set.
- On accept of channel g:
  - in_bit=1: cnt[g] <= min(cnt[g]+1, THRESH). Saturates at THRESH and stays there on further ones.
  - in_bit=0: cnt[g] <= 0.
  - ptr <= (g+1) mod NUM_CH.
- No accept: ptr holds.
- Event: fires when an accept moves cnt[g] from THRESH-1 to THRESH. Next cycle, ev_valid=1 and ev_ch=g.
  - No event while cnt stays saturated at THRESH.
  - For THRESH=1, every 1 after a 0 (or after reset/clr) fires.
- Event register: cleared on ev_valid & ev_ready. A new event may load in the same cycle as the handshake, giving back-to-back events.
  - While stalled, no grants occur, so no event can be lost.
- Latency: accept edge -> ev_valid and match high 1 cycle later.
- clr[i] sets cnt[i] <= 0. If clr[i] coincides with an accept on i, clr wins: cnt=0, no event, ptr still advances.
  - clr never touches a pending event.
- enable=0 mid-run: counts, ptr and event are held; ev handshake still completes.
- match[i] is registered from next-state cnt, so it aligns with ev_valid.

Decomposition:
- Package run_detect_pkg: ch_idx_t (CH_W bits), cnt_t (CNT_W bits), THRESH_DEFAULT, and function sat_inc(cnt, thresh).
- Sub-module rr_arbiter: inputs req[NUM_CH], ptr, en; outputs one-hot gnt and gnt_idx. It is reused by other lane schedulers.
- The counter array, pointer and event register stay in the top.

Test Plan:
- Reset, then ch0 valid with bits 1,1,1,0 (THRESH=2) -> ev_valid with ev_ch=0 exactly once, one cycle after the 2nd accept. match[0] goes 0,0,1,1,0.
- All 4 channels valid continuously -> grants cycle 0,1,2,3,0. Each channel is granted exactly once per 4 accepts.
- Ch1 and ch3 reach the threshold on consecutive grants with ev_ready=0 -> first event is ch1. in_ready=0 until ev_ready=1. Then the ch3 event follows; no loss.
- clr[2]=1 in the same cycle as an accepted 1 on ch2 whose cnt=1 -> cnt[2]=0, no event, ptr=3.
- enable=0 for 5 cycles with valids high -> in_ready=0, counts held. Re-enable -> grant resumes from the held ptr.
- Assert reset low asynchronously while ev_valid=1 and cnt[0]=2 -> ev_valid, match and in_ready drop immediately without a clock edge; all counts are 0 after release.
